// File: rtl/poly_io_sequencer_if.sv
// Bus bundle between the operand sequencer, the operand BRAM and the polynomial register bank.
interface poly_io_sequencer_if #(
  parameter int unsigned WORD_WIDTH = 17,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  bram_rd_en_o;
  logic [ADDR_WIDTH-1:0] bram_rd_addr_o;
  logic [WORD_WIDTH-1:0] bram_rd_data_i;
  logic                  bram_wr_en_o;
  logic [ADDR_WIDTH-1:0] bram_wr_addr_o;
  logic [WORD_WIDTH-1:0] bram_wr_data_o;
  logic [1:0]            input_reg_sel_o;
  logic                  input_reg_en_o;
  logic [WORD_WIDTH-1:0] input_reg_din_o;
  logic [WORD_WIDTH-1:0] res_dout_i;
  logic                  res_reg_shift_o;

  // Sequencer side.
  modport master (
    output bram_rd_en_o, bram_rd_addr_o, bram_wr_en_o, bram_wr_addr_o, bram_wr_data_o,
    output input_reg_sel_o, input_reg_en_o, input_reg_din_o, res_reg_shift_o,
    input  bram_rd_data_i, res_dout_i
  );

  // BRAM / register-bank side.
  modport slave (
    input  bram_rd_en_o, bram_rd_addr_o, bram_wr_en_o, bram_wr_addr_o, bram_wr_data_o,
    input  input_reg_sel_o, input_reg_en_o, input_reg_din_o, res_reg_shift_o,
    output bram_rd_data_i, res_dout_i
  );
endinterface

// File: rtl/poly_io_sequencer.sv
// Moves operands A, B, M, M_prime_0 from BRAM into the register bank and shifts the result
// register back out to BRAM. Read-enable and select travel through a BRAM_LATENCY-deep pipe
// so the bank strobe lines up with the returning data.
module poly_io_sequencer #(
  parameter int unsigned WORD_WIDTH   = 17,
  parameter int unsigned N            = 5,
  parameter int unsigned S            = 4,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned BRAM_LATENCY = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_load_i,
  input  logic                  start_store_i,
  input  logic [ADDR_WIDTH-1:0] load_base_i,
  input  logic [ADDR_WIDTH-1:0] store_base_i,
  poly_io_sequencer_if.master   bus,
  output logic                  busy_o,
  output logic                  load_done_o,
  output logic                  store_done_o
);

  localparam int unsigned NumCoefWords = N * S;
  localparam int unsigned LoadWords    = 3 * NumCoefWords + N;
  localparam int unsigned CntMax       = (LoadWords > BRAM_LATENCY) ? LoadWords : BRAM_LATENCY;
  localparam int unsigned CntWidth     = $clog2(CntMax + 1);

  typedef logic [CntWidth-1:0] cnt_t;

  localparam cnt_t LoadLast  = cnt_t'(LoadWords - 1);
  localparam cnt_t StoreLast = cnt_t'(NumCoefWords - 1);
  localparam cnt_t DrainLast = cnt_t'(BRAM_LATENCY - 1);
  localparam cnt_t BoundB    = cnt_t'(NumCoefWords);
  localparam cnt_t BoundM    = cnt_t'(2 * NumCoefWords);
  localparam cnt_t BoundMp   = cnt_t'(3 * NumCoefWords);

  typedef enum logic [2:0] {
    StIdle, StLoadIssue, StLoadDrain, StStore, StDoneLoad, StDoneStore
  } state_e;

  state_e                state_q, state_d;
  cnt_t                  k_q, k_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  shift_q, shift_d;
  logic                  busy_q, busy_d;
  logic                  load_done_q, load_done_d;
  logic                  store_done_q, store_done_d;
  logic [1:0]            issue_sel;
  logic [BRAM_LATENCY-1:0] pipe_v_q;
  logic [1:0]              pipe_sel_q [BRAM_LATENCY];
  logic [WORD_WIDTH-1:0]   rd_data;

  // Region of the word currently being issued: A, B, M, then the short M_prime_0 block.
  always_comb begin
    if (k_q < BoundB) begin
      issue_sel = 2'd0;
    end else if (k_q < BoundM) begin
      issue_sel = 2'd1;
    end else if (k_q < BoundMp) begin
      issue_sel = 2'd2;
    end else begin
      issue_sel = 2'd3;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    shift_d      = 1'b0;
    busy_d       = 1'b0;
    load_done_d  = 1'b0;
    store_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Load has priority; a simultaneous store command is dropped.
        if (start_load_i) begin
          state_d   = StLoadIssue;
          k_d       = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = load_base_i;
          busy_d    = 1'b1;
        end else if (start_store_i) begin
          state_d   = StStore;
          k_d       = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = store_base_i;
          shift_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      StLoadIssue: begin
        busy_d = 1'b1;
        if (k_q == LoadLast) begin
          state_d = StLoadDrain;
          k_d     = '0;
        end else begin
          k_d       = k_q + cnt_t'(1);
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        end
      end
      StLoadDrain: begin
        busy_d = 1'b1;
        if (k_q == DrainLast) begin
          state_d     = StDoneLoad;
          load_done_d = 1'b1;
        end else begin
          k_d = k_q + cnt_t'(1);
        end
      end
      StStore: begin
        busy_d = 1'b1;
        if (k_q == StoreLast) begin
          state_d      = StDoneStore;
          store_done_d = 1'b1;
        end else begin
          k_d       = k_q + cnt_t'(1);
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
          shift_d   = 1'b1;
        end
      end
      StDoneLoad, StDoneStore: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      k_q          <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      shift_q      <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      shift_q      <= shift_d;
      busy_q       <= busy_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
    end
  end

  // Read-latency pipe: valid and select emerge in the cycle the BRAM data does.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pipe_v_q <= '0;
      for (int i = 0; i < BRAM_LATENCY; i++) begin
        pipe_sel_q[i] <= 2'd0;
      end
    end else begin
      pipe_v_q[0]   <= rd_en_q;
      pipe_sel_q[0] <= rd_en_q ? issue_sel : 2'd0;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        pipe_v_q[i]   <= pipe_v_q[i-1];
        pipe_sel_q[i] <= pipe_sel_q[i-1];
      end
    end
  end

  assign rd_data = bus.bram_rd_data_i;

  assign bus.bram_rd_en_o    = rd_en_q;
  assign bus.bram_rd_addr_o  = rd_addr_q;
  assign bus.bram_wr_en_o    = wr_en_q;
  assign bus.bram_wr_addr_o  = wr_addr_q;
  assign bus.bram_wr_data_o  = bus.res_dout_i;
  assign bus.input_reg_sel_o = pipe_sel_q[BRAM_LATENCY-1];
  assign bus.input_reg_en_o  = pipe_v_q[BRAM_LATENCY-1];
  assign bus.input_reg_din_o = rd_data;
  assign bus.res_reg_shift_o = shift_q;
  assign busy_o              = busy_q;
  assign load_done_o         = load_done_q;
  assign store_done_o        = store_done_q;

endmodule

// File: tb/tb_poly_io_sequencer.sv
// Bench for poly_io_sequencer: table of load/store operations (fixed and random) checked
// cycle by cycle against a timeline model, plus a reset-mid-load sequence.
module tb_poly_io_sequencer;
  localparam int WW = 17;
  localparam int NN = 5;
  localparam int SS = 4;
  localparam int AW = 10;
  localparam int BL = 2;
  localparam int NS = NN * SS;
  localparam int LW = 3 * NS + NN;
  localparam int SW = NS;
  localparam int AMASK = (1 << AW) - 1;

  typedef struct {
    int          kind;      // 0 load, 1 store, 2 both starts together
    logic [9:0]  base;
    bit          rnd_data;
    bit          mid;       // pulse the other start mid-operation
    int          exp_done;  // cycle index of the done pulse, t0 = 0
    int          exp_strobes;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_load = 1'b0;
  logic start_store = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [AW-1:0] store_base = '0;
  logic busy, load_done, store_done;

  logic [WW-1:0] mem [1 << AW];
  logic [WW-1:0] bank [NS];
  logic [WW-1:0] bram_pipe [BL];
  int bank_idx;

  int n_checks = 0;
  int n_fail = 0;

  poly_io_sequencer_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

  poly_io_sequencer #(
    .WORD_WIDTH(WW), .N(NN), .S(SS), .ADDR_WIDTH(AW), .BRAM_LATENCY(BL)
  ) dut (
    .clock_i(clock),
    .reset_i(reset),
    .start_load_i(start_load),
    .start_store_i(start_store),
    .load_base_i(load_base),
    .store_base_i(store_base),
    .bus(bus),
    .busy_o(busy),
    .load_done_o(load_done),
    .store_done_o(store_done)
  );

  always #5 clock = ~clock;

  // BRAM read model with BL cycles of latency.
  always @(posedge clock) begin
    bram_pipe[0] <= bus.bram_rd_en_o ? mem[bus.bram_rd_addr_o] : '0;
    for (int i = 1; i < BL; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign bus.bram_rd_data_i = bram_pipe[BL-1];

  // Result register model: shifts one word per strobe, rewinds on a store command.
  always @(posedge clock) begin
    if (start_store) bank_idx <= 0;
    else if (bus.res_reg_shift_o) bank_idx <= bank_idx + 1;
  end
  assign bus.res_dout_i = (bank_idx >= 0 && bank_idx < NS) ? bank[bank_idx] : '0;

  task automatic chk(input string name, input int c, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, c, act, exp);
    end
  endtask

  function automatic int region(input int j);
    if (j < NS) return 0;
    if (j < 2 * NS) return 1;
    if (j < 3 * NS) return 2;
    return 3;
  endfunction

  // Called just after a falling edge; returns just after the falling edge of the first idle cycle.
  task automatic run_op(input vec_t v);
    int  done_c = -1;
    int  strobes = 0;
    bit  is_load = (v.kind != 1);
    int  last = is_load ? LW + BL : SW;
    for (int a = 0; a < (1 << AW); a++)
      mem[a] = v.rnd_data ? WW'($urandom) : WW'(((a - int'(v.base)) & AMASK) + 1);
    for (int j = 0; j < NS; j++) bank[j] = v.rnd_data ? WW'($urandom) : WW'('hA0 + j);
    start_load  = (v.kind != 1);
    start_store = (v.kind != 0);
    load_base   = v.base;
    store_base  = v.base;
    @(posedge clock);
    @(negedge clock);
    start_load  = 1'b0;
    start_store = 1'b0;
    for (int c = 0; c <= v.exp_done + 1; c++) begin
      int  j = c - BL;
      bit  e_rd = is_load && c < LW;
      bit  e_en = is_load && j >= 0 && j < LW;
      bit  e_wr = !is_load && c < SW;
      if (c > 0) @(negedge clock);
      chk("rd_en", c, bus.bram_rd_en_o, e_rd);
      if (e_rd) chk("rd_addr", c, bus.bram_rd_addr_o, (int'(v.base) + c) & AMASK);
      chk("in_en", c, bus.input_reg_en_o, e_en);
      if (e_en) begin
        chk("in_sel", c, bus.input_reg_sel_o, region(j));
        chk("in_din", c, bus.input_reg_din_o, mem[(int'(v.base) + j) & AMASK]);
      end
      chk("wr_en", c, bus.bram_wr_en_o, e_wr);
      chk("shift", c, bus.res_reg_shift_o, e_wr);
      if (e_wr) begin
        chk("wr_addr", c, bus.bram_wr_addr_o, (int'(v.base) + c) & AMASK);
        chk("wr_data", c, bus.bram_wr_data_o, bank[c]);
      end
      chk("load_done", c, load_done, is_load && c == last);
      chk("store_done", c, store_done, !is_load && c == last);
      chk("busy", c, busy, c <= last);
      if (bus.input_reg_en_o || bus.bram_wr_en_o) strobes++;
      if ((load_done || store_done) && done_c < 0) done_c = c;
      if (v.mid) begin
        if (is_load) start_store = (c == 10);
        else start_load = (c == 5);
        load_base  = 10'h2C3;
        store_base = 10'h1A1;
      end
    end
    start_load  = 1'b0;
    start_store = 1'b0;
    chk("strobe_count", -1, strobes, v.exp_strobes);
    chk("done_cycle", -1, done_c, v.exp_done);
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{kind: 0, base: 10'h100, rnd_data: 0, mid: 0, exp_done: 67, exp_strobes: 65};
    vecs[1] = '{kind: 1, base: 10'h200, rnd_data: 0, mid: 0, exp_done: 20, exp_strobes: 20};
    vecs[2] = '{kind: 0, base: 10'h3F0, rnd_data: 0, mid: 0, exp_done: 67, exp_strobes: 65};
    vecs[3] = '{kind: 2, base: 10'h155, rnd_data: 1, mid: 0, exp_done: 67, exp_strobes: 65};
    vecs[4] = '{kind: 0, base: 10'h080, rnd_data: 1, mid: 1, exp_done: 67, exp_strobes: 65};
    vecs[5] = '{kind: 1, base: 10'h3F8, rnd_data: 1, mid: 1, exp_done: 20, exp_strobes: 20};
    for (int i = 6; i < 10; i++) begin
      int k = int'($urandom_range(0, 2));
      vecs[i] = '{kind: k, base: 10'($urandom), rnd_data: 1, mid: 0,
                  exp_done: (k == 1) ? 20 : 67, exp_strobes: (k == 1) ? 20 : 65};
    end
    for (int j = 0; j < NS; j++) bank[j] = '0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_rd_en", 0, bus.bram_rd_en_o, 0);
    chk("rst_rd_addr", 0, bus.bram_rd_addr_o, 0);
    chk("rst_wr_en", 0, bus.bram_wr_en_o, 0);
    chk("rst_in_en", 0, bus.input_reg_en_o, 0);
    chk("rst_shift", 0, bus.res_reg_shift_o, 0);
    chk("rst_busy", 0, busy, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Reset in the middle of a load at t0+30.
    for (int a = 0; a < (1 << AW); a++) mem[a] = WW'($urandom);
    start_load = 1'b1;
    load_base  = 10'h2A0;
    @(posedge clock);
    @(negedge clock);
    start_load = 1'b0;
    repeat (30) @(negedge clock);
    chk("pre_rst_rd_en", 30, bus.bram_rd_en_o, 1);
    chk("pre_rst_in_en", 30, bus.input_reg_en_o, 1);
    reset = 1'b1;
    #1;
    chk("arst_rd_en", 30, bus.bram_rd_en_o, 0);
    chk("arst_rd_addr", 30, bus.bram_rd_addr_o, 0);
    chk("arst_wr_en", 30, bus.bram_wr_en_o, 0);
    chk("arst_wr_addr", 30, bus.bram_wr_addr_o, 0);
    chk("arst_sel", 30, bus.input_reg_sel_o, 0);
    chk("arst_in_en", 30, bus.input_reg_en_o, 0);
    chk("arst_shift", 30, bus.res_reg_shift_o, 0);
    chk("arst_busy", 30, busy, 0);
    chk("arst_load_done", 30, load_done, 0);
    chk("arst_store_done", 30, store_done, 0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < BL + 3; i++) begin
      @(negedge clock);
      chk("post_rst_in_en", i, bus.input_reg_en_o, 0);
      chk("post_rst_rd_en", i, bus.bram_rd_en_o, 0);
      chk("post_rst_busy", i, busy, 0);
    end
    run_op('{kind: 0, base: 10'h2A0, rnd_data: 1, mid: 0, exp_done: 67, exp_strobes: 65});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/poly_io_sequencer.md
# poly_io_sequencer

Controller that moves polynomial operands between the operand BRAM and the polynomial register bank, and writes results back. On a load command it streams operands A, B, M and M_prime_0 out of BRAM and drives the bank's input-register select and enable strobes, compensating for BRAM read latency. On a store command it shifts the bank's result register out word by word into BRAM. It sits between the top-level multiplier controller and the register bank/BRAM pair.

## Interface
Parameters:
- WORD_WIDTH, 17, word width of BRAM data and register-bank input/output words
- N, 5, coefficients per AMNS polynomial
- S, 4, WORD_WIDTH blocks per coefficient
- ADDR_WIDTH, 10, BRAM address width
- BRAM_LATENCY, 2, cycles from read issue to data valid on bram_rd_data_i (≥1)

Ports:
- clock_i  in  1  single clock, all logic on rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_load_i  in  1  one-cycle load command, sampled only in IDLE
- start_store_i  in  1  one-cycle store command, sampled only in IDLE
- load_base_i  in  ADDR_WIDTH  base address of operand block, latched on accepted start_load_i
- store_base_i  in  ADDR_WIDTH  base address of result block, latched on accepted start_store_i
- bram_rd_en_o  out  1  BRAM read enable
- bram_rd_addr_o  out  ADDR_WIDTH  BRAM read address
- bram_rd_data_i  in  WORD_WIDTH  BRAM read data
- bram_wr_en_o  out  1  BRAM write enable
- bram_wr_addr_o  out  ADDR_WIDTH  BRAM write address
- bram_wr_data_o  out  WORD_WIDTH  BRAM write data, combinational copy of res_dout_i
- input_reg_sel_o  out  2  bank input select: 0 A, 1 B, 2 M, 3 M_prime_0
- input_reg_en_o  out  1  bank input-register write strobe
- input_reg_din_o  out  WORD_WIDTH  bank input data, combinational copy of bram_rd_data_i
- res_dout_i  in  WORD_WIDTH  bank result-register low word
- res_reg_shift_o  out  1  bank result-register shift strobe
- busy_o  out  1  high outside IDLE
- load_done_o  out  1  one-cycle pulse at load completion
- store_done_o  out  1  one-cycle pulse at store completion

## Operation
- States: IDLE, LOAD_ISSUE, LOAD_DRAIN, STORE, DONE_LOAD, DONE_STORE.
- IDLE: start_load_i=1 -> latch load_base_i, counter k=0, go LOAD_ISSUE. Otherwise, start_store_i=1 -> latch store_base_i, k=0, go STORE. If both are high, load wins and the store command is dropped.
- Starts outside IDLE are ignored (not queued).
- LOAD_ISSUE: one read per cycle, k=0..3NS+N-1 (65 by default), bram_rd_addr_o = base+k modulo 2^ADDR_WIDTH.
- Region select for word k: k<NS ->0, k<2NS ->1, k<3NS ->2, else 3.
- Valid and select are carried through a BRAM_LATENCY-deep pipeline. input_reg_en_o and input_reg_sel_o are asserted together in the cycle the data is on bram_rd_data_i.
- After the last issue, go LOAD_DRAIN for BRAM_LATENCY cycles until the pipeline empties, then DONE_LOAD.
- STORE: for k=0..NS-1, assert bram_wr_en_o=1, bram_wr_addr_o=base+k (wrapping), and res_reg_shift_o=1 in the same cycle. The bank presents the next word in the following cycle. After k=NS-1, go DONE_STORE.
- DONE_LOAD/DONE_STORE: pulse the matching done output for one cycle, return to IDLE.
- Reset (asynchronous, also mid-operation): state IDLE, counters and pipeline cleared. All registered outputs go to 0: rd_en, rd_addr, wr_en, wr_addr, sel, en, res_reg_shift, busy, both done pulses. Pending read data is discarded with no en strobe.

## Timing
- All outputs are registered except bram_wr_data_o and input_reg_din_o.
- The start edge is sampled at edge E. Cycle t0 is the cycle following E.
- Load:
  - bram_rd_en_o=1 from t0 to t0+64.
  - input_reg_en_o=1 from t0+L to t0+64+L (L = BRAM_LATENCY).
  - load_done_o=1 at t0+65+L.
  - busy_o=1 from t0 through the done cycle.
- Store:
  - bram_wr_en_o and res_reg_shift_o=1 from t0 to t0+NS-1.
  - store_done_o=1 at t0+NS.
- Load latency with defaults is 68 cycles from start to done inclusive. Store latency is 21 cycles.
- After a done pulse, the next start is accepted in the cycle following the return to IDLE.

## Test plan
- Load with defaults: base=0x100, BRAM word k = k+1. Expect 65 en strobes starting at t0+2. Sel is 0 for words 1..20, 1 for 21..40, 2 for 41..60, 3 for 61..65. load_done_o at t0+67.
- Store with defaults: base=0x200, res_dout_i driven by a bank model holding 0xA0..0xB3. Expect writes to 0x200..0x213 with data 0xA0..0xB3, 20 shift strobes, store_done_o at t0+20.
- Address wrap: load_base_i=0x3F0 with ADDR_WIDTH=10. Read addresses run 0x3F0..0x3FF, then 0x000..0x030.
- Simultaneous start_load_i and start_store_i in IDLE: only the load executes. No write strobes occur, and store_done_o never pulses.
- Start during busy: pulse start_store_i mid-load. It is ignored, and the load timing is unchanged.
- Reset mid-load at t0+30: all outputs 0 immediately. No en strobe for in-flight reads. A new load after reset completes normally.
